cart_mem_ctrl: RTL

CART_MEM_CTRL -- requirements
Module: cart_mem_ctrl

---
 rtl/cart_mem_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/cart_mem_ctrl.sv
// rtl/cart_mem_ctrl.sv - cartridge async SRAM controller, 8-bit bus, four-phase transfers
// Strobes are registered so the memory sees glitch-free, edge-aligned control.
module cart_mem_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  inout  wire  [7:0]        I_O,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       io_en;

  assign I_O = io_en ? wdata_q : 8'hzz;
  assign UB  = 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      io_en   <= 1'b0;
      rdata   <= 8'h00;
      done    <= 1'b0;
      busy    <= 1'b0;
      A       <= '0;
      CE      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      LB      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= SETUP;
            A       <= addr;
            we_q    <= we_req;
            wdata_q <= wdata;
            busy    <= 1'b1;
            CE      <= 1'b0;
            LB      <= 1'b0;
            OE      <= we_req;
            WE      <= 1'b1;
            io_en   <= we_req;
          end
        end
        SETUP: begin
          // Address and write data have now been stable a full cycle.
          state <= ACCESS;
          cnt   <= 4'd0;
          if (we_q) WE <= 1'b0;
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state <= HOLD;
            WE    <= 1'b1;
            OE    <= 1'b1;
            done  <= 1'b1;
            if (!we_q) rdata <= I_O;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          // WE rose last edge; only now may CE, A and I_O move.
          state <= IDLE;
          cnt   <= 4'd0;
          CE    <= 1'b1;
          LB    <= 1'b1;
          io_en <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
